// File: rtl/m_ucode_seq.sv
// m_ucode_seq -- microcode sequencer for the 3-EBR control ROM.
//
// Picks the next micro-address and the ROM read enable each cycle from the
// current ROM word, the dispatch index, the branch condition and the bus
// busy flag. It also covers the boot fetch, the bus-wait timeout trap and
// the insertion of interrupts at dispatch points.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   ucode_next     next-address field of the current ROM word
//   ucode_mode     sequencing mode: 00 SEQ, 01 DISPATCH, 10 BRANCH, 11 WAIT
//   dispatch_inx   opcode-derived micro-address used by DISPATCH
//   cond           branch condition used by BRANCH
//   mem_busy       bus not ready; stalls WAIT words
//   irq            level interrupt request
//   minx           ROM read address (combinational)
//   progress_ucode ROM read enable (combinational)
//   instret        registered one-cycle pulse per dispatch taken
//   bus_err        sticky bus-wait timeout flag, cleared only by reset
module m_ucode_seq #(
  parameter logic [7:0]  RESET_UADDR = 8'h00,
  parameter logic [7:0]  IRQ_UADDR   = 8'hE0,
  parameter logic [7:0]  TRAP_UADDR  = 8'hF0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ucode_next,
  input  logic [1:0] ucode_mode,
  input  logic [7:0] dispatch_inx,
  input  logic       cond,
  input  logic       mem_busy,
  input  logic       irq,
  output logic [7:0] minx,
  output logic       progress_ucode,
  output logic       instret,
  output logic       bus_err
);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    M_SEQ      = 2'b00,
    M_DISPATCH = 2'b01,
    M_BRANCH   = 2'b10,
    M_WAIT     = 2'b11
  } mode_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state, state_nxt;
  mode_t      mode;
  logic [7:0] cnt, cnt_nxt;
  logic       irq_pend, irq_pend_nxt;
  logic       instret_nxt;
  logic       bus_err_nxt;
  logic       take_irq;

  assign mode = mode_t'(ucode_mode);

  always_comb begin
    state_nxt      = RUN;
    minx           = ucode_next;
    progress_ucode = 1'b1;
    cnt_nxt        = '0;
    take_irq       = 1'b0;
    instret_nxt    = 1'b0;
    bus_err_nxt    = bus_err;

    if (state == BOOT) begin
      minx = RESET_UADDR;
    end else begin
      unique case (mode)
        M_SEQ: minx = ucode_next;
        M_DISPATCH: begin
          take_irq    = irq_pend;
          minx        = irq_pend ? IRQ_UADDR : dispatch_inx;
          instret_nxt = 1'b1;
        end
        M_BRANCH: minx = cond ? ucode_next : ucode_next + 8'd1;
        M_WAIT: begin
          // mem_busy low wins over an expiring counter, so no trap then.
          if (!mem_busy) begin
            minx = ucode_next;
          end else if (cnt == TIMEOUT_CNT) begin
            minx        = TRAP_UADDR;
            bus_err_nxt = 1'b1;
          end else begin
            progress_ucode = 1'b0;
            cnt_nxt        = cnt + 8'd1;
          end
        end
        default: minx = ucode_next;
      endcase
    end

    // A new request in the same cycle as the IRQ dispatch keeps it pending.
    irq_pend_nxt = irq | (irq_pend & ~take_irq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      cnt      <= '0;
      irq_pend <= 1'b0;
      instret  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      irq_pend <= irq_pend_nxt;
      instret  <= instret_nxt;
      bus_err  <= bus_err_nxt;
    end
  end

endmodule

// File: tb/tb_m_ucode_seq.sv
// Testbench for m_ucode_seq: a driver applies one ROM word per cycle and
// queues the expected outputs; a monitor pops and compares them mid-cycle.
module tb_m_ucode_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ucode_next = '0;
  logic [1:0] ucode_mode = '0;
  logic [7:0] dispatch_inx = '0;
  logic       cond = 1'b0;
  logic       mem_busy = 1'b0;
  logic       irq = 1'b0;
  logic [7:0] minx;
  logic       progress_ucode;
  logic       instret;
  logic       bus_err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  typedef struct packed {
    logic [7:0] minx;
    logic       pu;
    logic       ir;
    logic       be;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  localparam logic [1:0] SEQ = 2'b00, DSP = 2'b01, BRA = 2'b10, WAI = 2'b11;

  m_ucode_seq #(
    .RESET_UADDR(8'h00),
    .IRQ_UADDR  (8'hE0),
    .TRAP_UADDR (8'hF0),
    .TIMEOUT    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ucode_next    (ucode_next),
    .ucode_mode    (ucode_mode),
    .dispatch_inx  (dispatch_inx),
    .cond          (cond),
    .mem_busy      (mem_busy),
    .irq           (irq),
    .minx          (minx),
    .progress_ucode(progress_ucode),
    .instret       (instret),
    .bus_err       (bus_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply one ROM word at the falling edge and queue what must be seen.
  task automatic drive(input logic [1:0] m, input logic [7:0] nx, input logic [7:0] dx,
                       input logic c, input logic b, input logic i,
                       input logic [7:0] em, input logic ep, input logic ei,
                       input logic eb, input string tag);
    exp_t e;
    @(negedge clk);
    ucode_mode   = m;
    ucode_next   = nx;
    dispatch_inx = dx;
    cond         = c;
    mem_busy     = b;
    irq          = i;
    e.minx = em;
    e.pu   = ep;
    e.ir   = ei;
    e.be   = eb;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".minx"}, 32'(minx), 32'(e.minx));
        check({t, ".re"},   32'(progress_ucode), 32'(e.pu));
        check({t, ".instret"}, 32'(instret), 32'(e.ir));
        check({t, ".bus_err"}, 32'(bus_err), 32'(e.be));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst.minx", 32'(minx), 32'h00);
    check("rst.re", 32'(progress_ucode), 32'h1);
    check("rst.instret", 32'(instret), 32'h0);
    check("rst.bus_err", 32'(bus_err), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //    mode nxt    disp   c  b  i   minx   re ir be  tag
    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, "boot");
    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h12, 1, 0, 0, "seq1");
    drive(BRA, 8'h40, 8'h00, 1, 0, 0, 8'h40, 1, 0, 0, "br_taken");
    drive(BRA, 8'h40, 8'h00, 0, 0, 0, 8'h41, 1, 0, 0, "br_fall");
    drive(BRA, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, "br_wrap");
    drive(DSP, 8'h00, 8'h87, 0, 0, 0, 8'h87, 1, 0, 0, "disp");
    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h12, 1, 1, 0, "instret_hi");
    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h12, 1, 0, 0, "instret_lo");
    drive(SEQ, 8'h50, 8'h00, 0, 0, 1, 8'h50, 1, 0, 0, "irq_pulse");
    drive(DSP, 8'h00, 8'h87, 0, 0, 0, 8'hE0, 1, 0, 0, "disp_irq");
    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h12, 1, 1, 0, "irq_instret");
    drive(DSP, 8'h00, 8'h33, 0, 0, 0, 8'h33, 1, 0, 0, "pend_clear");
    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h12, 1, 1, 0, "seq2");
    drive(SEQ, 8'h12, 8'h00, 0, 0, 1, 8'h12, 1, 0, 0, "irq_set");
    drive(DSP, 8'h00, 8'h44, 0, 0, 1, 8'hE0, 1, 0, 0, "irq_setwins");
    drive(DSP, 8'h00, 8'h44, 0, 0, 0, 8'hE0, 1, 1, 0, "irq_again");
    drive(DSP, 8'h00, 8'h44, 0, 0, 0, 8'h44, 1, 1, 0, "disp_after");
    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h12, 1, 1, 0, "seq3");
    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h12, 1, 0, 0, "seq4");
    repeat (3)
      drive(WAI, 8'h30, 8'h00, 0, 1, 0, 8'h30, 0, 0, 0, "stall3");
    drive(WAI, 8'h30, 8'h00, 0, 0, 0, 8'h30, 1, 0, 0, "stall3_done");
    repeat (4)
      drive(WAI, 8'h55, 8'h00, 0, 1, 0, 8'h55, 0, 0, 0, "stall4");
    drive(WAI, 8'h55, 8'h00, 0, 0, 0, 8'h55, 1, 0, 0, "busy_drop_at_limit");
    repeat (4)
      drive(WAI, 8'h77, 8'h00, 0, 1, 0, 8'h77, 0, 0, 0, "stuck");
    drive(WAI, 8'h77, 8'h00, 0, 1, 0, 8'hF0, 1, 0, 0, "trap");
    drive(WAI, 8'h77, 8'h00, 0, 1, 0, 8'h77, 0, 0, 1, "after_trap");
    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h12, 1, 0, 1, "err_sticky");
    drive(WAI, 8'h66, 8'h00, 0, 1, 0, 8'h66, 0, 0, 1, "stall_a");
    drive(WAI, 8'h66, 8'h00, 0, 1, 0, 8'h66, 0, 0, 1, "stall_b");
    drive(WAI, 8'h66, 8'h00, 0, 1, 0, 8'h66, 0, 0, 1, "stall_c");

    // Counter is 2 here; reset lands mid-cycle, away from any clock edge.
    #5 rst = 1'b1;
    #2;
    check("arst.minx", 32'(minx), 32'h00);
    check("arst.re", 32'(progress_ucode), 32'h1);
    check("arst.instret", 32'(instret), 32'h0);
    check("arst.bus_err", 32'(bus_err), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, "reboot");
    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h12, 1, 0, 0, "reboot_seq");
    repeat (4)
      drive(WAI, 8'h66, 8'h00, 0, 1, 0, 8'h66, 0, 0, 0, "fresh_stall");
    drive(WAI, 8'h66, 8'h00, 0, 1, 0, 8'hF0, 1, 0, 0, "fresh_trap");
    drive(SEQ, 8'h12, 8'h00, 0, 0, 0, 8'h12, 1, 0, 1, "fresh_err");

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    #5;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
